// File: rtl/phase_addr_gen.sv
// Multi-channel phase-address generator: shared up/down/ping-pong accumulator driving
// NCH registered ROM addresses (base - offset). Define SYNC_UPDATE_EN for wrap-aligned offset updates.
module phase_addr_gen #(
  parameter int WIDTH = 9,
  parameter int NCH   = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    clr,
  input  logic [1:0]                              mode,
  input  logic [WIDTH-1:0]                        incr,
  input  logic                                    wr_en,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
  input  logic [WIDTH-1:0]                        wr_data,
  output logic [NCH*WIDTH-1:0]                    addr,
  output logic [WIDTH-1:0]                        base,
  output logic                                    wrap
);

  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  dir_t             dir;
  dir_t             next_dir;
  logic [WIDTH-1:0] next_base;
  logic             next_wrap;
  logic [WIDTH:0]   sum;
  logic             wr_hit;

  logic [WIDTH-1:0] off_active [NCH];

`ifdef SYNC_UPDATE_EN
  logic [WIDTH-1:0] off_shadow [NCH];
  logic [NCH-1:0]   pending;
  logic             commit;

  assign commit = clr || next_wrap;
`endif

  assign wr_hit = wr_en && (int'(wr_ch) < NCH);

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    sum       = {1'b0, base} + {1'b0, incr};
    next_base = base;
    next_dir  = (mode_t'(mode) == MODE_PING) ? dir : DIR_UP;
    next_wrap = 1'b0;

    if (clr) begin
      next_base = '0;
      next_dir  = DIR_UP;
    end else if (en && (incr != '0)) begin
      case (mode_t'(mode))
        MODE_UP: begin
          next_base = sum[WIDTH-1:0];
          next_wrap = sum[WIDTH];
        end
        MODE_DOWN: begin
          next_base = base - incr;
          next_wrap = (base < incr);
        end
        MODE_PING: begin
          if (dir == DIR_UP) begin
            if (sum > {1'b0, MAX}) begin
              next_base = MAX;
              next_dir  = DIR_DOWN;
            end else begin
              next_base = sum[WIDTH-1:0];
            end
          end else if (base <= incr) begin
            // Reaching zero on the descent closes one full period.
            next_base = '0;
            next_dir  = DIR_UP;
            next_wrap = 1'b1;
          end else begin
            next_base = base - incr;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      dir  <= DIR_UP;
      wrap <= 1'b0;
      addr <= '0;
      // NOTE: the offset array is a handful of flops that must read zero after reset, so it is cleared.
      for (int k = 0; k < NCH; k++) begin
        off_active[k] <= '0;
`ifdef SYNC_UPDATE_EN
        off_shadow[k] <= '0;
`endif
      end
`ifdef SYNC_UPDATE_EN
      pending <= '0;
`endif
    end else begin
      base <= next_base;
      dir  <= next_dir;
      wrap <= next_wrap;
      // Addresses use the offsets held before this edge so they align with base.
      for (int k = 0; k < NCH; k++) begin
        addr[k*WIDTH +: WIDTH] <= next_base - off_active[k];
      end
`ifdef SYNC_UPDATE_EN
      for (int k = 0; k < NCH; k++) begin
        if (commit) begin
          off_active[k] <= off_shadow[k];
          pending[k]    <= 1'b0;
        end
        // A write on the commit edge lands in shadow and stays pending for the next commit.
        if (wr_hit && (int'(wr_ch) == k)) begin
          off_shadow[k] <= wr_data;
          pending[k]    <= 1'b1;
        end
      end
`else
      for (int k = 0; k < NCH; k++) begin
        if (wr_hit && (int'(wr_ch) == k)) begin
          off_active[k] <= wr_data;
        end
      end
`endif
    end
  end

endmodule
